// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with error flags, overrun and error counting
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     parity_error,
    input  logic                     stop_error,
    input  logic                     rd_ready,
    input  logic                     flush,
    input  logic                     clr_overrun,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_parity_err,
    output logic                     rd_stop_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overrun,
    output logic [7:0]               err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] AF_LVL   = AF_THRESH[AW:0];

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rx_valid_d;

    logic push_evt;
    logic pop;
    logic wr_en;
    logic rd_en;
    logic drop;
    logic err_inc;
    logic [9:0] head;

    assign empty       = (count == '0);
    assign full        = (count == FULL_LVL);
    assign almost_full = (count >= AF_LVL);
    assign rd_valid    = !empty;

    // One push per rx_valid high period; rx_valid_d resets high so a level
    // already present at reset release is not taken as a new byte.
    assign push_evt = rx_valid & ~rx_valid_d;
    assign pop      = rd_valid & rd_ready;

    // flush discards the incoming byte and any pop; a full FIFO still accepts
    // when the head leaves in the same cycle.
    assign wr_en   = push_evt & ~flush & (~full | pop);
    assign rd_en   = pop & ~flush;
    assign drop    = push_evt & ~flush & full & ~pop;
    assign err_inc = wr_en & (parity_error | stop_error) & (err_count != 8'hFF);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {stop_error, parity_error, rx_data};
        end
    end

    // Memory is not reset, so the head is masked to zero while empty.
    assign head          = mem[rd_ptr];
    assign rd_data       = rd_valid ? head[7:0] : 8'h00;
    assign rd_parity_err = rd_valid ? head[8]   : 1'b0;
    assign rd_stop_err   = rd_valid ? head[9]   : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_d <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_count  <= 8'h00;
        end else begin
            rx_valid_d <= rx_valid;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                err_count <= 8'h00;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
                if (err_inc) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    // A drop in the same cycle as clr_overrun leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
